// File: rtl/scmp_useq.sv
// scmp_useq: microcode sequencer that drives the PLA address mc_pc.
// mc_pc can come from decode targets, interrupt entry, a return-stack pop,
// conditional fall-through or a relative next offset. It also has a bus-wait
// stall and sticky stack-error flags.
module scmp_useq #(
   parameter int unsigned         PC_W        = 8,
   parameter int unsigned         NEXT_W      = 8,
   parameter int unsigned         COND_W      = 6,
   parameter int unsigned         STACK_D     = 4,
   parameter bit                  NEXT_SIGNED = 1'b0,
   parameter logic [PC_W-1:0]     IRQ_VEC     = 8'hF0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          stall,
   input  logic                          ctl_decode,
   input  logic                          ctl_ret,
   input  logic                          ctl_call,
   input  logic [NEXT_W-1:0]             nextpc,
   input  logic [COND_W-1:0]             cond_in,
   input  logic [COND_W-1:0]             cond_mask,
   input  logic [COND_W-1:0]             cond_xor,
   input  logic [PC_W-1:0]               op_pc,
   input  logic                          irq_req,
   input  logic                          irq_en,
   output logic [PC_W-1:0]               mc_pc,
   output logic                          irq_ack,
   output logic [$clog2(STACK_D+1)-1:0]  sp,
   output logic                          err_ovf,
   output logic                          err_unf
);

   localparam int unsigned SP_W = $clog2(STACK_D + 1);

   // Entry 0 is always the top of stack. Push and pop shift the whole array,
   // so no occupancy-based indexing is needed.
   logic [PC_W-1:0] stk [STACK_D];

   logic            cond;
   logic            irq_take;
   logic            empty;
   logic            full;
   logic            st_push;
   logic            st_pop;
   logic            st_repl;
   logic            set_ovf;
   logic            set_unf;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] next_ext;
   logic [PC_W-1:0] pc_nxt;

   // Condition evaluation, stack-operation classification and next-PC choice
   always_comb begin
      cond     = |((cond_in ^ cond_xor) & cond_mask);
      pc_inc   = mc_pc + PC_W'(1);
      irq_take = ctl_decode & irq_req & irq_en;
      empty    = (sp == '0);
      full     = (sp == SP_W'(STACK_D));

      // call+ret on an empty stack behaves as a plain push.
      st_push  = ctl_call & (ctl_ret ? empty : ~full);
      st_pop   = ctl_ret & ~ctl_call & ~empty;
      st_repl  = ctl_ret & ctl_call & ~empty;
      set_ovf  = ctl_call & ~ctl_ret & full;
      set_unf  = ctl_ret & empty;

      if (NEXT_SIGNED)
         next_ext = PC_W'($signed(nextpc));
      else
         next_ext = PC_W'(nextpc);

      pc_nxt = '0;
      if (ctl_decode)
         pc_nxt = irq_take ? IRQ_VEC : op_pc;
      else if (ctl_ret)
         pc_nxt = empty ? '0 : stk[0];
      else if (cond)
         pc_nxt = pc_inc;
      else if (nextpc == '0)
         pc_nxt = '0;
      else
         pc_nxt = mc_pc + next_ext;
   end

   // Control registers: PC, occupancy, interrupt ack and sticky error flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mc_pc   <= '0;
         sp      <= '0;
         irq_ack <= 1'b0;
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else if (stall) begin
         irq_ack <= 1'b0;
      end else begin
         mc_pc   <= pc_nxt;
         irq_ack <= irq_take;
         if (st_push)
            sp <= sp + SP_W'(1);
         else if (st_pop)
            sp <= sp - SP_W'(1);
         if (set_ovf)
            err_ovf <= 1'b1;
         if (set_unf)
            err_unf <= 1'b1;
      end
   end

   // Return-stack storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (rst_n && !stall) begin
         if (st_push) begin
            stk[0] <= pc_inc;
            for (int unsigned i = 1; i < STACK_D; i++)
               stk[i] <= stk[i-1];
         end else if (st_pop) begin
            for (int unsigned i = 0; i + 1 < STACK_D; i++)
               stk[i] <= stk[i+1];
         end else if (st_repl) begin
            stk[0] <= pc_inc;
         end
      end
   end

endmodule

// File: tb/tb_scmp_useq.sv
// tb_scmp_useq: directed bench for scmp_useq with a scoreboard queue.
// Instance u_a uses the defaults. Instance u_b has a 4-bit signed nextpc
// field, so it tells sign-extension apart from zero-extension.
module tb_scmp_useq;

   logic       clk = 1'b0;
   logic       rst_n, stall, ctl_decode, ctl_ret, ctl_call;
   logic [7:0] nextpc;
   logic [5:0] cond_in, cond_mask, cond_xor;
   logic [7:0] op_pc;
   logic       irq_req, irq_en;

   logic [7:0] mc_pc;
   logic       irq_ack, err_ovf, err_unf;
   logic [2:0] sp;

   logic [7:0] b_pc;
   logic       b_ack, b_ovf, b_unf;
   logic [2:0] b_sp;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      tag;
      logic [7:0] pc;
      logic [2:0] sp;
      logic       ack;
      logic       ovf;
      logic       unf;
      bit         chk_b;
      logic [7:0] pc_b;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   scmp_useq u_a (
      .clk(clk), .rst_n(rst_n), .stall(stall), .ctl_decode(ctl_decode),
      .ctl_ret(ctl_ret), .ctl_call(ctl_call), .nextpc(nextpc),
      .cond_in(cond_in), .cond_mask(cond_mask), .cond_xor(cond_xor),
      .op_pc(op_pc), .irq_req(irq_req), .irq_en(irq_en),
      .mc_pc(mc_pc), .irq_ack(irq_ack), .sp(sp),
      .err_ovf(err_ovf), .err_unf(err_unf)
   );

   scmp_useq #(.NEXT_W(4), .NEXT_SIGNED(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .stall(stall), .ctl_decode(ctl_decode),
      .ctl_ret(ctl_ret), .ctl_call(ctl_call), .nextpc(nextpc[3:0]),
      .cond_in(cond_in), .cond_mask(cond_mask), .cond_xor(cond_xor),
      .op_pc(op_pc), .irq_req(irq_req), .irq_en(irq_en),
      .mc_pc(b_pc), .irq_ack(b_ack), .sp(b_sp),
      .err_ovf(b_ovf), .err_unf(b_unf)
   );

   task automatic clr();
      stall      = 1'b0;
      ctl_decode = 1'b0;
      ctl_ret    = 1'b0;
      ctl_call   = 1'b0;
      nextpc     = 8'h01;
      cond_in    = '0;
      cond_mask  = '0;
      cond_xor   = '0;
      op_pc      = '0;
      irq_req    = 1'b0;
      irq_en     = 1'b0;
   endtask

   task automatic check();
      exp_t       e;
      logic [13:0] obs, req;
      e   = sbq.pop_front();
      obs = {mc_pc, sp, irq_ack, err_ovf, err_unf};
      req = {e.pc, e.sp, e.ack, e.ovf, e.unf};
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed pc=%h sp=%0d ack=%b ovf=%b unf=%b, required pc=%h sp=%0d ack=%b ovf=%b unf=%b",
                e.tag, mc_pc, sp, irq_ack, err_ovf, err_unf, e.pc, e.sp, e.ack, e.ovf, e.unf);
      end
      if (e.chk_b) begin
         checks++;
         assert (b_pc === e.pc_b) else begin
            errors++;
            $error("FAIL %s_signed: observed pc=%h, required pc=%h", e.tag, b_pc, e.pc_b);
         end
      end
   endtask

   // Expected values go into the queue when the step is driven. They are
   // popped and compared 1 time unit after the active edge.
   task automatic tick_x(input string tag, input logic [7:0] pc, input logic [2:0] s,
                         input logic a, input logic o, input logic u,
                         input bit cb, input logic [7:0] pcb);
      exp_t e;
      e.tag = tag; e.pc = pc; e.sp = s; e.ack = a; e.ovf = o; e.unf = u;
      e.chk_b = cb; e.pc_b = pcb;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      check();
      clr();
   endtask

   task automatic tick(input string tag, input logic [7:0] pc, input logic [2:0] s,
                       input logic a, input logic o, input logic u);
      tick_x(tag, pc, s, a, o, u, 1'b0, 8'h00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      clr();
      rst_n = 1'b0;
      tick("rst0", 8'h00, 0, 0, 0, 0);
      tick("rst1", 8'h00, 0, 0, 0, 0);
      rst_n = 1'b1;

      // Plain stepping and the zero next offset
      tick("step1", 8'h01, 0, 0, 0, 0);
      tick("step2", 8'h02, 0, 0, 0, 0);
      tick("step3", 8'h03, 0, 0, 0, 0);
      nextpc = 8'h00;                        tick("next0", 8'h00, 0, 0, 0, 0);

      // Decode and conditional fall-through
      ctl_decode = 1; op_pc = 8'h40;         tick("dec40", 8'h40, 0, 0, 0, 0);
      cond_mask = 6'b000010; cond_in = 6'b000010; nextpc = 8'h05;
                                             tick("cond_t", 8'h41, 0, 0, 0, 0);
      cond_mask = 6'b000010; nextpc = 8'h05; tick("cond_f", 8'h46, 0, 0, 0, 0);
      cond_mask = 6'b000010; cond_xor = 6'b000010; nextpc = 8'h05;
                                             tick("xor_t", 8'h47, 0, 0, 0, 0);
      cond_mask = 6'b000010; cond_xor = 6'b000010; cond_in = 6'b000010; nextpc = 8'h05;
                                             tick("xor_f", 8'h4C, 0, 0, 0, 0);

      // PC wrap, and zero- versus sign-extension of nextpc
      ctl_decode = 1; op_pc = 8'hFF;         tick("decFF", 8'hFF, 0, 0, 0, 0);
      nextpc = 8'h01;                        tick("wrap", 8'h00, 0, 0, 0, 0);
      ctl_decode = 1; op_pc = 8'h03;         tick_x("dec03", 8'h03, 0, 0, 0, 0, 1'b1, 8'h03);
      nextpc = 8'h0E;                        tick_x("ext0E", 8'h11, 0, 0, 0, 0, 1'b1, 8'h01);
      ctl_decode = 1; op_pc = 8'h03;         tick("dec03b", 8'h03, 0, 0, 0, 0);
      nextpc = 8'hFE;                        tick_x("extFE", 8'h01, 0, 0, 0, 0, 1'b1, 8'h01);

      // Nested calls and returns
      ctl_decode = 1; op_pc = 8'h10;         tick("dec10", 8'h10, 0, 0, 0, 0);
      ctl_decode = 1; op_pc = 8'h20; ctl_call = 1; tick("call20", 8'h20, 1, 0, 0, 0);
      ctl_decode = 1; op_pc = 8'h30; ctl_call = 1; tick("call30", 8'h30, 2, 0, 0, 0);
      ctl_ret = 1;                           tick("ret21", 8'h21, 1, 0, 0, 0);
      ctl_ret = 1;                           tick("ret11", 8'h11, 0, 0, 0, 0);

      // Fill the stack, overflow it, then drain it past empty
      ctl_call = 1;                          tick("push1", 8'h12, 1, 0, 0, 0);
      ctl_call = 1;                          tick("push2", 8'h13, 2, 0, 0, 0);
      ctl_call = 1;                          tick("push3", 8'h14, 3, 0, 0, 0);
      ctl_call = 1;                          tick("push4", 8'h15, 4, 0, 0, 0);
      ctl_call = 1;                          tick("push_ovf", 8'h16, 4, 0, 1, 0);
      ctl_ret = 1;                           tick("pop_top", 8'h15, 3, 0, 1, 0);
      ctl_ret = 1;                           tick("pop3", 8'h14, 2, 0, 1, 0);
      ctl_ret = 1;                           tick("pop2", 8'h13, 1, 0, 1, 0);
      ctl_ret = 1;                           tick("pop1", 8'h12, 0, 0, 1, 0);
      ctl_ret = 1;                           tick("pop_unf", 8'h00, 0, 0, 1, 1);

      // Simultaneous call and return replaces the top entry
      ctl_decode = 1; op_pc = 8'h10;         tick("dec10b", 8'h10, 0, 0, 1, 1);
      ctl_decode = 1; op_pc = 8'h30; ctl_call = 1; tick("call30b", 8'h30, 1, 0, 1, 1);
      ctl_call = 1; ctl_ret = 1;             tick("callret", 8'h11, 1, 0, 1, 1);
      ctl_ret = 1;                           tick("ret31", 8'h31, 0, 0, 1, 1);

      // Error flags clear only on reset; call+ret on an empty stack
      rst_n = 1'b0;                          tick("rst2", 8'h00, 0, 0, 0, 0);
      rst_n = 1'b1;
      ctl_call = 1; ctl_ret = 1;             tick("callret0", 8'h00, 1, 0, 0, 1);
      ctl_ret = 1;                           tick("ret01", 8'h01, 0, 0, 0, 1);
      rst_n = 1'b0;                          tick("rst3", 8'h00, 0, 0, 0, 0);
      rst_n = 1'b1;

      // Interrupt entry at decode boundaries only
      ctl_decode = 1; op_pc = 8'h40; irq_req = 1; irq_en = 1;
                                             tick("irq", 8'hF0, 0, 1, 0, 0);
      irq_req = 1; irq_en = 1;               tick("irq_mid", 8'hF1, 0, 0, 0, 0);
      ctl_decode = 1; op_pc = 8'h40; irq_req = 1; irq_en = 1;
                                             tick("irq_a", 8'hF0, 0, 1, 0, 0);
      ctl_decode = 1; op_pc = 8'h40; irq_req = 1; irq_en = 1;
                                             tick("irq_held", 8'hF0, 0, 1, 0, 0);
      ctl_decode = 1; op_pc = 8'h40; irq_req = 1; irq_en = 0;
                                             tick("irq_dis", 8'h40, 0, 0, 0, 0);

      // A stall freezes state and clears the ack; the call completes once
      ctl_decode = 1; op_pc = 8'h40; irq_req = 1; irq_en = 1;
                                             tick("irq_b", 8'hF0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         stall = 1; ctl_call = 1; ctl_decode = 1; op_pc = 8'h40; irq_req = 1; irq_en = 1;
         tick("stall", 8'hF0, 0, 0, 0, 0);
      end
      ctl_call = 1;                          tick("call_after", 8'hF1, 1, 0, 0, 0);
      tick("stepF2", 8'hF2, 1, 0, 0, 0);
      ctl_ret = 1;                           tick("retF1", 8'hF1, 0, 0, 0, 0);

      // Reset while stalled
      ctl_call = 1;                          tick("callF2", 8'hF2, 1, 0, 0, 0);
      stall = 1;                             tick("stall2", 8'hF2, 1, 0, 0, 0);
      stall = 1; ctl_call = 1; rst_n = 1'b0; tick("rst_stall", 8'h00, 0, 0, 0, 0);
      rst_n = 1'b1;                          tick("post_rst", 8'h01, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
